// File: rtl/treasure_detect_ctrl.sv
// Treasure detection sequencer: waits out filter settle frames, votes on per-frame
// RESULT codes, reports a stable code (or timeout) over a four-phase REQ/VALID handshake.
module treasure_detect_ctrl #(
    parameter int SKIP_FRAMES   = 4,
    parameter int STABLE_FRAMES = 3,
    parameter int MAX_FRAMES    = 30,
    parameter int CNT_W         = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VGA_VSYNC_NEG,
    input  logic [2:0] RESULT,
    input  logic       REQ,
    output logic [2:0] DATA_OUT,
    output logic       VALID,
    output logic       TIMEOUT,
    output logic       BUSY
);

    localparam logic [CNT_W-1:0] LP_SKIP   = CNT_W'(SKIP_FRAMES);
    localparam logic [CNT_W-1:0] LP_STABLE = CNT_W'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] LP_MAX    = CNT_W'(MAX_FRAMES);
    localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_VOTE,
        S_DONE
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + LP_ONE;
    endfunction

    state_t           r_state, w_state_nxt;
    logic             r_req_meta, r_req_s, r_req_d;
    logic [1:0]       r_warm;
    logic             r_armed, w_armed_nxt;
    logic             r_vs_d, r_frame_tick;
    logic             w_fall;
    logic [CNT_W-1:0] r_skip, w_skip_nxt;
    logic [CNT_W-1:0] r_frame, w_frame_nxt;
    logic [CNT_W-1:0] r_run, w_run_nxt;
    logic [2:0]       r_cand, w_cand_nxt;
    logic [2:0]       r_data, w_data_nxt;
    logic             r_timeout, w_to_nxt;
    logic             r_valid, r_busy;
    logic [CNT_W-1:0] w_vote_run, w_vote_frame;

    assign w_fall = r_vs_d & ~VGA_VSYNC_NEG;

    // r_warm marks when req_s reflects REQ sampled after reset, so a REQ held
    // high through reset is never mistaken for a fresh rising edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_req_meta   <= 1'b0;
            r_req_s      <= 1'b0;
            r_req_d      <= 1'b0;
            r_warm       <= 2'b00;
            r_vs_d       <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_req_meta   <= REQ;
            r_req_s      <= r_req_meta;
            r_req_d      <= r_req_s;
            r_warm       <= {r_warm[0], 1'b1};
            r_vs_d       <= VGA_VSYNC_NEG;
            r_frame_tick <= w_fall;
        end
    end

    assign w_vote_run   = (RESULT == r_cand && r_run != '0) ? sat_inc(r_run) : LP_ONE;
    assign w_vote_frame = sat_inc(r_frame);

    always_comb begin
        w_state_nxt = r_state;
        w_armed_nxt = r_armed;
        w_skip_nxt  = r_skip;
        w_frame_nxt = r_frame;
        w_run_nxt   = r_run;
        w_cand_nxt  = r_cand;
        w_data_nxt  = r_data;
        w_to_nxt    = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (r_warm[1] && !r_req_s)
                    w_armed_nxt = 1'b1;
                if (r_armed && r_req_s && !r_req_d) begin
                    w_armed_nxt = 1'b0;
                    w_skip_nxt  = '0;
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!r_req_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_skip == LP_SKIP) begin
                    w_frame_nxt = '0;
                    w_run_nxt   = '0;
                    w_cand_nxt  = 3'b000;
                    w_state_nxt = S_VOTE;
                end else if (r_frame_tick) begin
                    w_skip_nxt = sat_inc(r_skip);
                end
            end
            S_VOTE: begin
                if (!r_req_s) begin
                    w_state_nxt = S_IDLE;
                end else if (r_frame_tick) begin
                    w_frame_nxt = w_vote_frame;
                    w_run_nxt   = w_vote_run;
                    w_cand_nxt  = RESULT;
                    // Stable result is checked first so it wins a same-tick timeout.
                    if (w_vote_run == LP_STABLE) begin
                        w_data_nxt  = RESULT;
                        w_to_nxt    = 1'b0;
                        w_state_nxt = S_DONE;
                    end else if (w_vote_frame == LP_MAX) begin
                        w_data_nxt  = 3'b000;
                        w_to_nxt    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!r_req_s)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_armed   <= 1'b0;
            r_skip    <= '0;
            r_frame   <= '0;
            r_run     <= '0;
            r_cand    <= 3'b000;
            r_data    <= 3'b000;
            r_timeout <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_armed   <= w_armed_nxt;
            r_skip    <= w_skip_nxt;
            r_frame   <= w_frame_nxt;
            r_run     <= w_run_nxt;
            r_cand    <= w_cand_nxt;
            r_data    <= w_data_nxt;
            r_timeout <= w_to_nxt;
            r_valid   <= (w_state_nxt == S_DONE);
            r_busy    <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_VOTE);
        end
    end

    assign DATA_OUT = r_data;
    assign VALID    = r_valid;
    assign TIMEOUT  = r_timeout;
    assign BUSY     = r_busy;

endmodule

// File: tb/tb_treasure_detect_ctrl.sv
// Scoreboard bench for treasure_detect_ctrl: expected {code,timeout} queued per
// request, popped and compared when VALID rises.
module tb_treasure_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b1;
    logic [2:0] result = 3'b000;
    logic       req1 = 1'b0, req2 = 1'b0;
    logic [2:0] data1, data2;
    logic       valid1, valid2, to1, to2, busy1, busy2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] q1[$];
    logic [3:0] q2[$];

    always #5 clk = ~clk;

    treasure_detect_ctrl #(.SKIP_FRAMES(4), .STABLE_FRAMES(3), .MAX_FRAMES(30), .CNT_W(8)) u_dut1 (
        .CLK(clk), .RESET(rst), .VGA_VSYNC_NEG(vs), .RESULT(result), .REQ(req1),
        .DATA_OUT(data1), .VALID(valid1), .TIMEOUT(to1), .BUSY(busy1));

    treasure_detect_ctrl #(.SKIP_FRAMES(4), .STABLE_FRAMES(3), .MAX_FRAMES(3), .CNT_W(8)) u_dut2 (
        .CLK(clk), .RESET(rst), .VGA_VSYNC_NEG(vs), .RESULT(result), .REQ(req2),
        .DATA_OUT(data2), .VALID(valid2), .TIMEOUT(to2), .BUSY(busy2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_frame(input logic [2:0] code);
        @(negedge clk);
        result = code;
        vs = 1'b0;
        repeat (3) @(negedge clk);
        vs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frames(input logic [2:0] code, input int n);
        for (int i = 0; i < n; i++) do_frame(code);
    endtask

    // Raise REQ on dut1 and check BUSY appears exactly 3 clocks later.
    task automatic raise1(input string tag);
        @(negedge clk);
        req1 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_busy_early"}, 32'(busy1), 32'd0);
        @(negedge clk);
        chk({tag, "_busy"}, 32'(busy1), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int which);
        int n;
        logic v;
        logic [3:0] got, exp;
        n = 0;
        v = (which == 1) ? valid1 : valid2;
        while (!v && n < 50) begin
            @(negedge clk);
            n++;
            v = (which == 1) ? valid1 : valid2;
        end
        got = (which == 1) ? {data1, to1} : {data2, to2};
        if (!v) begin
            chk({tag, "_valid_timeout"}, 32'd0, 32'd1);
        end else if ((which == 1 ? q1.size() : q2.size()) == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            exp = (which == 1) ? q1.pop_front() : q2.pop_front();
            chk(tag, 32'(got), 32'(exp));
        end
    endtask

    task automatic drop1;
        @(negedge clk);
        req1 = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'({data1, valid1, to1, busy1}), 32'd0);
        repeat (4) @(negedge clk);

        // 1: settle on 010, then three 011 with exact VALID timing
        raise1("t1");
        frames(3'b010, 4);
        frames(3'b011, 2);
        chk("t1_no_valid_early", 32'(valid1), 32'd0);
        q1.push_back({3'b011, 1'b0});
        @(negedge clk);
        result = 3'b011;
        vs = 1'b0;
        @(negedge clk);
        chk("t1_valid_tick", 32'(valid1), 32'd0);
        @(negedge clk);
        chk("t1_valid_next", 32'(valid1), 32'd1);
        repeat (2) @(negedge clk);
        vs = 1'b1;
        repeat (4) @(negedge clk);
        wait_valid("t1_report", 1);
        chk("t1_busy_done", 32'(busy1), 32'd0);
        drop1();
        chk("t1_valid_drop", 32'(valid1), 32'd0);
        chk("t1_data_hold", 32'({data1, to1}), 32'({3'b011, 1'b0}));

        // 2: run broken and restarted
        raise1("t2");
        frames(3'b000, 4);
        do_frame(3'b001);
        do_frame(3'b101);
        do_frame(3'b101);
        do_frame(3'b001);
        do_frame(3'b001);
        chk("t2_no_valid_early", 32'(valid1), 32'd0);
        q1.push_back({3'b001, 1'b0});
        do_frame(3'b001);
        wait_valid("t2_report", 1);
        drop1();

        // 3: alternating codes -> timeout
        raise1("t3");
        frames(3'b000, 4);
        for (int i = 0; i < 29; i++) do_frame(i[0] ? 3'b010 : 3'b001);
        chk("t3_no_valid_early", 32'(valid1), 32'd0);
        q1.push_back({3'b000, 1'b1});
        do_frame(3'b010);
        wait_valid("t3_timeout", 1);
        drop1();

        // 4: MAX_FRAMES == STABLE_FRAMES, stable wins
        @(negedge clk);
        req2 = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_busy", 32'(busy2), 32'd1);
        frames(3'b000, 4);
        q2.push_back({3'b100, 1'b0});
        frames(3'b100, 3);
        wait_valid("t4_stable_wins", 2);
        @(negedge clk);
        req2 = 1'b0;
        repeat (5) @(negedge clk);

        // 5: abort during VOTE, then full restart
        raise1("t5");
        frames(3'b000, 4);
        frames(3'b110, 2);
        drop1();
        chk("t5_abort_busy", 32'(busy1), 32'd0);
        chk("t5_abort_valid", 32'(valid1), 32'd0);
        chk("t5_abort_hold", 32'({data1, to1}), 32'({3'b000, 1'b1}));
        raise1("t5r");
        frames(3'b111, 4);
        frames(3'b111, 2);
        chk("t5_full_skip", 32'(valid1), 32'd0);
        q1.push_back({3'b111, 1'b0});
        do_frame(3'b111);
        wait_valid("t5_report", 1);

        // 6: reset in DONE with REQ held high
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_out", 32'({data1, valid1, to1}), 32'd0);
        repeat (6) @(negedge clk);
        chk("t6_no_start", 32'(busy1), 32'd0);
        frames(3'b011, 5);
        chk("t6_no_start_frames", 32'({valid1, busy1}), 32'd0);
        drop1();
        raise1("t6r");
        drop1();

        chk("sb_drained", 32'(q1.size() + q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
